ysyx_25030081_mem_arbiter: RTL and testbench
============================================

YSYX_25030081_MEM_ARBITER -- requirements
Module: ysyx_25030081_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, sets the data width of all data ports.
REQ-003 Parameter TIMEOUT, default 255, is the number of cycles without completion before a transaction aborts; legal range 2..255.
REQ-004 One clock and synchronous active-high reset: clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ifu_req  in  1  instruction fetch request; held until ifu_gnt.
REQ-007 ifu_addr  in  ADDR_WIDTH  fetch address.
REQ-008 ifu_gnt  out  1  fetch request accepted this cycle.
REQ-009 ifu_rvalid  out  1  fetch response valid, one-cycle pulse.
REQ-010 ifu_rdata  out  DATA_WIDTH  fetched instruction.
REQ-011 ifu_err  out  1  fetch aborted by timeout; qualified by ifu_rvalid.
REQ-012 lsu_req  in  1  load/store request; held until lsu_gnt.
REQ-013 lsu_wen  in  1  1 = store, 0 = load.
REQ-014 lsu_addr  in  ADDR_WIDTH  load/store address.
REQ-015 lsu_wdata  in  DATA_WIDTH  store data.
REQ-016 lsu_wmask  in  DATA_WIDTH/8  store byte enables.
REQ-017 lsu_gnt  out  1  load/store request accepted this cycle.
REQ-018 lsu_rvalid  out  1  load data or store acknowledge, one-cycle pulse.
REQ-019 lsu_rdata  out  DATA_WIDTH  load data; 0 for stores.
REQ-020 lsu_err  out  1  load/store aborted by timeout; qualified by lsu_rvalid.
REQ-021 mem_req  out  1  downstream request valid.
REQ-022 mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  latched downstream command.
REQ-023 mem_ready  in  1  downstream accepts the command when mem_req and mem_ready are both high.
REQ-024 mem_rvalid  in  1  downstream response valid.
REQ-025 mem_rdata  in  DATA_WIDTH  downstream read data.

Function
REQ-026 FSM states: IDLE, REQ, WAIT, RESP; one transaction outstanding at a time.
REQ-027 IDLE with any request: gnt for the winner is asserted combinationally that cycle; addr/wen/wdata/wmask latched; next state REQ.
REQ-028 Both requests in IDLE: winner is the master not granted last (round-robin); last_grant updates on each grant.
REQ-029 The losing master gets no gnt and must keep its req high; it is granted at the next IDLE.
REQ-030 REQ: mem_req=1 with latched command; on mem_ready=1, next state WAIT and mem_req=0 from the next cycle.
REQ-031 WAIT: mem_req=0; on mem_rvalid=1, mem_rdata captured (0 for stores); next state RESP.
REQ-032 mem_rvalid is ignored outside WAIT; mem_ready is ignored outside REQ.
REQ-033 RESP: rvalid of the granted master is 1 for exactly one cycle with the registered rdata/err; next state IDLE; no gnt is issued in RESP.
REQ-034 Minimum latency with mem_ready and mem_rvalid each high on first opportunity: gnt in cycle 0, mem_req in cycle 1, rvalid in cycle 3.
REQ-035 The timeout counter clears on grant and increments each cycle in REQ or WAIT.
REQ-036 When the counter reaches TIMEOUT, the FSM goes to RESP with err=1 and rdata=0, and mem_req drops.
REQ-037 rdata/err outputs of the non-granted master are always 0; ifu_gnt and lsu_gnt are never both 1.

Reset
REQ-038 rst=1 forces IDLE, last_grant=LSU (IFU wins the first tie), counter=0, and all outputs 0 on the next edge.
REQ-039 rst mid-transaction abandons it with no rvalid pulse.

Verification
REQ-040 IFU-only fetch at 0x80000000, mem_ready=1 in cycle 1, mem_rvalid in cycle 2 with 0x00100093 -> ifu_gnt cycle 0; ifu_rvalid cycle 3, ifu_rdata=0x00100093, ifu_err=0.
REQ-041 ifu_req and lsu_req both high from reset for 4 back-to-back transactions -> grant order IFU, LSU, IFU, LSU.
REQ-042 LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_ready delayed 3 cycles -> mem_req held 4 cycles with stable command; lsu_rvalid=1, lsu_rdata=0.
REQ-043 TIMEOUT=8, mem_rvalid never asserted -> lsu_rvalid with lsu_err=1 and lsu_rdata=0 eight cycles after grant; then IDLE.
REQ-044 rst asserted in WAIT, then mem_rvalid pulses -> no rvalid output; next request is served normally.
REQ-045 Spurious mem_rvalid in IDLE and REQ -> no state change and no rvalid pulse.

Source files
------------

// File: rtl/ysyx_25030081_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// Grant is combinational in IDLE; response is a one-cycle rvalid pulse, or err after TIMEOUT cycles.
module ysyx_25030081_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_gnt,
  output logic                    ifu_rvalid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic                    ifu_err,

  input  logic                    lsu_req,
  input  logic                    lsu_wen,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_gnt,
  output logic                    lsu_rvalid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    lsu_err,

  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  // Abort is decided in the cycle before RESP so the err pulse lands TIMEOUT cycles after grant.
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 2);

  logic [1:0]            state_q;
  logic                  last_grant_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic pick_ifu;
  logic grant_any;
  logic timeout_hit;
  logic in_resp;

  always_comb begin
    pick_ifu    = ifu_req && (!lsu_req || last_grant_q == M_LSU);
    grant_any   = (state_q == IDLE) && !rst && (ifu_req || lsu_req);
    ifu_gnt     = grant_any && pick_ifu;
    lsu_gnt     = grant_any && !pick_ifu;
    timeout_hit = (cnt_q == CNT_LIMIT);
    in_resp     = (state_q == RESP);
    mem_req     = (state_q == REQ);
    ifu_rvalid  = in_resp && (last_grant_q == M_IFU);
    lsu_rvalid  = in_resp && (last_grant_q == M_LSU);
    ifu_rdata   = ifu_rvalid ? rdata_q : '0;
    ifu_err     = ifu_rvalid && err_q;
    lsu_rdata   = lsu_rvalid ? rdata_q : '0;
    lsu_err     = lsu_rvalid && err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= M_LSU;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mem_wen      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            last_grant_q <= pick_ifu ? M_IFU : M_LSU;
            cnt_q        <= '0;
            mem_wen      <= pick_ifu ? 1'b0 : lsu_wen;
            mem_addr     <= pick_ifu ? ifu_addr : lsu_addr;
            mem_wdata    <= pick_ifu ? '0 : lsu_wdata;
            mem_wmask    <= pick_ifu ? '0 : lsu_wmask;
            state_q      <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          // Timeout outranks a late handshake so WAIT can never start past the limit.
          if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else if (mem_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid) begin
            rdata_q <= mem_wen ? '0 : mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030081_mem_arbiter.sv
// Randomized bench for the memory arbiter; expectations come from a per-transaction latency model.
module tb_ysyx_25030081_mem_arbiter;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt, ifu_rvalid, ifu_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  bit last_lsu;

  always #5 clk = ~clk;

  ysyx_25030081_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] resp_vec();
    return 128'({ifu_rvalid, ifu_err, ifu_rdata, lsu_rvalid, lsu_err, lsu_rdata});
  endfunction

  function automatic logic [127:0] exp_resp(input bit ivld, input bit ierr, input logic [31:0] ird,
                                            input bit lvld, input bit lerr, input logic [31:0] lrd);
    return 128'({ivld, ierr, ird, lvld, lerr, lrd});
  endfunction

  // One transaction: d1 = cycles of mem_req before mem_ready, d2 = cycles of WAIT before mem_rvalid.
  task automatic do_txn(input bit m_lsu, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int d1, input int d2, input bit other_req, input logic [31:0] rd);
    int lat;
    bit err;
    logic [31:0] exp_rd;
    bit exp_mreq, resp_now;
    lat = 3 + d1 + d2;
    err = 1'b0;
    if (lat > T) begin
      lat = T;
      err = 1'b1;
    end
    exp_rd = (err || (m_lsu && wen)) ? 32'h0 : rd;

    @(negedge clk);
    if (m_lsu) begin
      lsu_req = 1'b1; lsu_wen = wen; lsu_addr = addr; lsu_wdata = wdata; lsu_wmask = wmask;
      ifu_req = other_req;
    end else begin
      ifu_req = 1'b1; ifu_addr = addr;
      lsu_req = other_req;
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    #1;
    chk("grant", 128'({ifu_gnt, lsu_gnt}), m_lsu ? 128'(2'b01) : 128'(2'b10));
    chk("idle_resp", resp_vec(), 128'(0));
    last_lsu = m_lsu;

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (m_lsu) lsu_req = 1'b0; else ifu_req = 1'b0;
      mem_ready  = (c >= 1 + d1);
      mem_rvalid = (c == 2 + d1 + d2) || (c <= 1 + d1 && $urandom_range(0, 1) == 1);
      mem_rdata  = (c == 2 + d1 + d2) ? rd : $urandom;
      #1;
      exp_mreq = (c <= 1 + d1) && (c < lat);
      resp_now = (c == lat);
      chk("mem_req", 128'(mem_req), 128'(exp_mreq));
      if (exp_mreq)
        chk("mem_cmd", 128'({mem_wen, mem_addr, mem_wdata, mem_wmask}),
            128'({m_lsu & wen, addr, m_lsu ? wdata : 32'h0, m_lsu ? wmask : 4'h0}));
      chk("no_gnt", 128'({ifu_gnt, lsu_gnt}), 128'(0));
      chk("resp", resp_vec(),
          exp_resp(resp_now && !m_lsu, resp_now && !m_lsu && err, (resp_now && !m_lsu) ? exp_rd : 32'h0,
                   resp_now && m_lsu, resp_now && m_lsu && err, (resp_now && m_lsu) ? exp_rd : 32'h0));
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ifu_req = 1'b0; lsu_req = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_ready  = 1'($urandom_range(0, 1));
    #1;
    chk("idle_quiet", 128'({mem_req, ifu_gnt, lsu_gnt}), 128'(0));
    chk("idle_resp", resp_vec(), 128'(0));
    mem_rvalid = 1'b0;
    mem_ready  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", 128'({ifu_gnt, lsu_gnt, mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask}), 128'(0));
    chk("reset_resp", resp_vec(), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    last_lsu = 1'b1;

    // Back-to-back contention from reset: IFU, LSU, IFU, LSU.
    do_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 1'b1, 32'h0010_0093);
    do_txn(1'b1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 0, 1'b1, 32'h1234_5678);
    do_txn(1'b0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 0, 1, 1'b1, 32'hCAFE_0001);
    do_txn(1'b1, 1'b0, 32'h8000_000C, 32'h0, 4'h0, 0, 0, 1'b0, 32'hCAFE_0002);

    // Store with ready held off for three cycles, then a load that times out.
    do_txn(1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3, 0, 1'b0, 32'h5555_AAAA);
    do_txn(1'b1, 1'b0, 32'h8000_2000, 32'h0, 4'h0, 0, 100, 1'b0, 32'h7777_7777);
    idle_cycle();

    // Reset while waiting for the response; the late response must be dropped.
    @(negedge clk);
    ifu_req = 1'b1; ifu_addr = 32'h8000_3000;
    #1;
    chk("rst_txn_gnt", 128'(ifu_gnt), 128'(1));
    @(negedge clk);
    ifu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("rst_txn_wait", 128'(mem_req), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rst_drop", resp_vec(), 128'(0));
    for (int i = 0; i < 3; i++) idle_cycle();
    last_lsu = 1'b1;
    do_txn(1'b0, 1'b0, 32'h8000_3000, 32'h0, 4'h0, 0, 0, 1'b1, 32'h0000_0013);
    do_txn(1'b1, 1'b0, 32'h8000_3004, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0000_0033);

    for (int r = 0; r < 30; r++) begin
      int kind;
      bit first;
      kind = int'($urandom_range(0, 2));
      if (kind == 2) begin
        first = !last_lsu;
        do_txn(first, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1'b1, $urandom);
        do_txn(!first, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1'b0, $urandom);
      end else begin
        do_txn(kind == 1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 1'b0, $urandom);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
